operand_unpack: RTL

OPERAND_UNPACK -- requirements
Module: operand_unpack

---
 rtl/fma_pkg.sv | 24 ++
 rtl/operand_classify.sv | 51 +++++
 rtl/operand_unpack.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fma_pkg.sv
// Shared constants and types for the FMA operand front end.
// Holds exponent bias, alignment offset, rounding-mode encodings and the per-operand class flags.
package fma_pkg;

    localparam int PARM_BIAS      = 127;
    localparam int PARM_ALIGN_OFS = 27;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } rm_e;

    typedef struct packed {
        logic den;
        logic zero;
        logic inf;
        logic nan;
        logic snan;
    } op_class_t;

endpackage

// File: rtl/operand_classify.sv
// Combinational IEEE-754 field split and class decode for one operand.
// With UNPACK_DAZ_EN defined, denormal inputs are reported as signed zero.
module operand_classify
    import fma_pkg::*;
#(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23
) (
    input  logic [PARM_EXP+PARM_MANT:0] op,
    output logic                        sign,
    output logic [PARM_EXP-1:0]         exp_raw,
    output logic [PARM_MANT:0]          mant,
    output logic [PARM_EXP-1:0]         ee,
    output op_class_t                   cls
);

    logic [PARM_EXP-1:0]  exp_f;
    logic [PARM_MANT-1:0] frac;
    logic                 exp_zero;
    logic                 exp_ones;
    logic                 frac_zero;

    assign exp_f     = op[PARM_MANT +: PARM_EXP];
    assign frac      = op[PARM_MANT-1:0];
    assign exp_zero  = (exp_f == '0);
    assign exp_ones  = &exp_f;
    assign frac_zero = (frac == '0);

    // NOTE: every output of a combinational block gets a value before any
    // conditional override; a path that skips an assignment infers a latch.
    always_comb begin
        sign     = op[PARM_EXP+PARM_MANT];
        exp_raw  = exp_f;
        mant     = {~exp_zero, frac};
        ee       = exp_zero ? PARM_EXP'(1) : exp_f;
        cls.den  = exp_zero & ~frac_zero;
        cls.zero = exp_zero & frac_zero;
        cls.inf  = exp_ones & frac_zero;
        cls.nan  = exp_ones & ~frac_zero;
        cls.snan = exp_ones & ~frac_zero & ~frac[PARM_MANT-1];
`ifdef UNPACK_DAZ_EN
        if (exp_zero & ~frac_zero) begin
            cls.den  = 1'b0;
            cls.zero = 1'b1;
            mant     = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/operand_unpack.sv
// Two-stage FMA operand unpack: stage 1 registers per-operand decode, stage 2 the exponent math.
// Optional denormals-are-zero behaviour is selected by the UNPACK_DAZ_EN macro.
module operand_unpack
    import fma_pkg::*;
#(
    parameter int PARM_EXP  = 8,
    parameter int PARM_MANT = 23,
    parameter int PARM_RM   = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [PARM_EXP+PARM_MANT:0] A_i,
    input  logic [PARM_EXP+PARM_MANT:0] B_i,
    input  logic [PARM_EXP+PARM_MANT:0] C_i,
    input  logic                        Sub_i,
    input  logic [PARM_RM-1:0]          Rounding_mode_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    input  logic                        flush_i,
    output logic                        A_Sign_o,
    output logic [PARM_EXP-1:0]         A_Exp_raw_o,
    output logic [PARM_MANT:0]          A_Mant_o,
    output logic                        A_DeN_o,
    output logic                        A_Zero_o,
    output logic                        A_Inf_o,
    output logic                        A_NaN_o,
    output logic                        A_SNaN_o,
    output logic                        B_Sign_o,
    output logic [PARM_EXP-1:0]         B_Exp_raw_o,
    output logic [PARM_MANT:0]          B_Mant_o,
    output logic                        B_DeN_o,
    output logic                        B_Zero_o,
    output logic                        B_Inf_o,
    output logic                        B_NaN_o,
    output logic                        B_SNaN_o,
    output logic                        C_Sign_o,
    output logic [PARM_EXP-1:0]         C_Exp_raw_o,
    output logic [PARM_MANT:0]          C_Mant_o,
    output logic                        C_DeN_o,
    output logic                        C_Zero_o,
    output logic                        C_Inf_o,
    output logic                        C_NaN_o,
    output logic                        C_SNaN_o,
    output logic                        Sub_Sign_o,
    output logic signed [PARM_EXP+1:0]  Exp_bc_o,
    output logic signed [PARM_EXP+1:0]  Exp_diff_o,
    output logic                        Exp_mv_sign_o,
    output logic [PARM_RM-1:0]          Rounding_mode_o,
    output logic                        Rm_invalid_o
);

    localparam int OW = PARM_EXP + PARM_MANT + 1;
    localparam int EW = PARM_EXP + 2;

    logic [OW-1:0]        op_in [3];
    logic [2:0]           d_sign;
    logic [PARM_EXP-1:0]  d_exp  [3];
    logic [PARM_EXP-1:0]  d_ee   [3];
    logic [PARM_MANT:0]   d_mant [3];
    op_class_t            d_cls  [3];

    assign op_in[0] = A_i;
    assign op_in[1] = B_i;
    assign op_in[2] = C_i;

    for (genvar i = 0; i < 3; i++) begin : g_op
        operand_classify #(
            .PARM_EXP  (PARM_EXP),
            .PARM_MANT (PARM_MANT)
        ) u_classify (
            .op      (op_in[i]),
            .sign    (d_sign[i]),
            .exp_raw (d_exp[i]),
            .mant    (d_mant[i]),
            .ee      (d_ee[i]),
            .cls     (d_cls[i])
        );
    end

    logic              rm_inv_c;
    logic [PARM_RM-1:0] rm_c;

    assign rm_inv_c = (Rounding_mode_i > PARM_RM'(RMM));
    assign rm_c     = rm_inv_c ? PARM_RM'(RNE) : Rounding_mode_i;

    // Handshake: stage 1 may move on whenever stage 2 is empty or being drained.
    logic s1_valid, s2_valid, s1_adv, accept;

    assign s1_adv     = ~s2_valid | out_ready_i;
    assign in_ready_o = (~s1_valid | s1_adv) & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s2_valid <= s1_valid;
            if (accept) s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;
        end
    end

    logic [2:0]          s1_sign;
    logic [PARM_EXP-1:0] s1_exp  [3];
    logic [PARM_EXP-1:0] s1_ee   [3];
    logic [PARM_MANT:0]  s1_mant [3];
    op_class_t           s1_cls  [3];
    logic                s1_sub_sign, s1_rm_inv;
    logic [PARM_RM-1:0]  s1_rm;

    // NOTE: datapath registers are reset too, because the data outputs must
    // read zero while in reset, not just be qualified by the valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_sign     <= '0;
            s1_sub_sign <= 1'b0;
            s1_rm       <= '0;
            s1_rm_inv   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                s1_exp[i]  <= '0;
                s1_ee[i]   <= '0;
                s1_mant[i] <= '0;
                s1_cls[i]  <= '0;
            end
        end else if (accept) begin
            s1_sign     <= d_sign;
            s1_sub_sign <= ^{d_sign, Sub_i};
            s1_rm       <= rm_c;
            s1_rm_inv   <= rm_inv_c;
            for (int i = 0; i < 3; i++) begin
                s1_exp[i]  <= d_exp[i];
                s1_ee[i]   <= d_ee[i];
                s1_mant[i] <= d_mant[i];
                s1_cls[i]  <= d_cls[i];
            end
        end
    end

    logic signed [EW-1:0] exp_bc_c, exp_diff_c;
    logic signed [EW:0]   mv_sum_c;

    // Extra headroom bit keeps the alignment-offset sum from wrapping.
    always_comb begin
        exp_bc_c   = EW'(s1_ee[1]) + EW'(s1_ee[2]) - EW'(PARM_BIAS);
        exp_diff_c = exp_bc_c - EW'(s1_ee[0]);
        mv_sum_c   = {exp_diff_c[EW-1], exp_diff_c} + (EW+1)'(PARM_ALIGN_OFS);
    end

    logic [2:0]           s2_sign;
    logic [PARM_EXP-1:0]  s2_exp  [3];
    logic [PARM_MANT:0]   s2_mant [3];
    op_class_t            s2_cls  [3];
    logic                 s2_sub_sign, s2_rm_inv, s2_mv;
    logic [PARM_RM-1:0]   s2_rm;
    logic signed [EW-1:0] s2_exp_bc, s2_exp_diff;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_sign     <= '0;
            s2_sub_sign <= 1'b0;
            s2_rm       <= '0;
            s2_rm_inv   <= 1'b0;
            s2_mv       <= 1'b0;
            s2_exp_bc   <= '0;
            s2_exp_diff <= '0;
            for (int i = 0; i < 3; i++) begin
                s2_exp[i]  <= '0;
                s2_mant[i] <= '0;
                s2_cls[i]  <= '0;
            end
        end else if (s1_adv && s1_valid) begin
            s2_sign     <= s1_sign;
            s2_sub_sign <= s1_sub_sign;
            s2_rm       <= s1_rm;
            s2_rm_inv   <= s1_rm_inv;
            s2_mv       <= mv_sum_c[EW];
            s2_exp_bc   <= exp_bc_c;
            s2_exp_diff <= exp_diff_c;
            for (int i = 0; i < 3; i++) begin
                s2_exp[i]  <= s1_exp[i];
                s2_mant[i] <= s1_mant[i];
                s2_cls[i]  <= s1_cls[i];
            end
        end
    end

    assign out_valid_o     = s2_valid;
    assign Sub_Sign_o      = s2_sub_sign;
    assign Exp_bc_o        = s2_exp_bc;
    assign Exp_diff_o      = s2_exp_diff;
    assign Exp_mv_sign_o   = s2_mv;
    assign Rounding_mode_o = s2_rm;
    assign Rm_invalid_o    = s2_rm_inv;

    assign A_Sign_o    = s2_sign[0];
    assign A_Exp_raw_o = s2_exp[0];
    assign A_Mant_o    = s2_mant[0];
    assign A_DeN_o     = s2_cls[0].den;
    assign A_Zero_o    = s2_cls[0].zero;
    assign A_Inf_o     = s2_cls[0].inf;
    assign A_NaN_o     = s2_cls[0].nan;
    assign A_SNaN_o    = s2_cls[0].snan;

    assign B_Sign_o    = s2_sign[1];
    assign B_Exp_raw_o = s2_exp[1];
    assign B_Mant_o    = s2_mant[1];
    assign B_DeN_o     = s2_cls[1].den;
    assign B_Zero_o    = s2_cls[1].zero;
    assign B_Inf_o     = s2_cls[1].inf;
    assign B_NaN_o     = s2_cls[1].nan;
    assign B_SNaN_o    = s2_cls[1].snan;

    assign C_Sign_o    = s2_sign[2];
    assign C_Exp_raw_o = s2_exp[2];
    assign C_Mant_o    = s2_mant[2];
    assign C_DeN_o     = s2_cls[2].den;
    assign C_Zero_o    = s2_cls[2].zero;
    assign C_Inf_o     = s2_cls[2].inf;
    assign C_NaN_o     = s2_cls[2].nan;
    assign C_SNaN_o    = s2_cls[2].snan;

endmodule
